fixed_point_divider: RTL and testbench

- Sequential unsigned fixed-point divider, Q(WIDTH-FBITS).FBITS format; the inverse operation to the Fixed_Point_Unit multiplier path.
- Sits beside Fixed_Point_Unit in the execute stage and shares its operand and result conventions.
- Computes result = (operand_1 << FBITS) / operand_2 by restoring division, one quotient bit per clock.
- Flags divide-by-zero and overflow, and saturates the result on either.

---
 rtl/fixed_point_divider.sv | 154 +++++++++++++++
 tb/tb_fixed_point_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider.sv
// Sequential unsigned fixed-point divider, Q(WIDTH-FBITS).FBITS operands and result.
// Restoring division of (operand_1 << FBITS) by operand_2, one quotient bit per clock.
// Divide-by-zero and quotient overflow both saturate the result to all-ones.
module fixed_point_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned QW = WIDTH + FBITS;
  localparam int unsigned CW = $clog2(QW + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [QW-1:0]    shift_q, shift_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [QW-1:0]    quot_q, quot_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  // Partial remainder with the next dividend bit brought in, and the trial subtraction.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [QW-1:0]    quot_next;

  // Datapath for one restoring-division step.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], shift_q[QW-1]};
    rem_ge    = rem_shift >= {1'b0, divisor_q};
    rem_sub   = rem_shift - {1'b0, divisor_q};
    quot_next = {quot_q[QW-2:0], rem_ge};
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    shift_d   = shift_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    count_d   = count_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d = 1'b1;
          if (operand_2 != '0) begin
            divisor_d = operand_2;
            shift_d   = QW'(operand_1) << FBITS;
            rem_d     = '0;
            quot_d    = '0;
            count_d   = CW'(QW);
            dbz_d     = 1'b0;
            ovf_d     = 1'b0;
            state_d   = StCalc;
          end else begin
            // No iterations needed: saturate and report straight away.
            result_d = '1;
            dbz_d    = 1'b1;
            ovf_d    = 1'b0;
            ready_d  = 1'b1;
            state_d  = StDone;
          end
        end
      end

      StCalc: begin
        rem_d   = rem_ge ? rem_sub : rem_shift;
        shift_d = shift_q << 1;
        quot_d  = quot_next;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          ready_d = 1'b1;
          state_d = StDone;
          // Any set bit above the integer range means the result cannot be represented.
          if (quot_next[QW-1:WIDTH] != '0) begin
            result_d = '1;
            ovf_d    = 1'b1;
          end else begin
            result_d = quot_next[WIDTH-1:0];
          end
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      divisor_q <= '0;
      shift_q   <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      count_q   <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      shift_q   <= shift_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      count_q   <= count_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign result      = result_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_fixed_point_divider;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned FBITS = 10;
  localparam int          LAT   = WIDTH + FBITS;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] operand_1 = '0;
  logic [WIDTH-1:0] operand_2 = '0;
  logic [WIDTH-1:0] result;
  logic             ready;
  logic             busy;
  logic             div_by_zero;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  fixed_point_divider #(
    .WIDTH(WIDTH),
    .FBITS(FBITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .result     (result),
    .ready      (ready),
    .busy       (busy),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {div_by_zero, overflow, result} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_div(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    longint unsigned q;
    if (b == '0) return {1'b1, 1'b0, {WIDTH{1'b1}}};
    q = (longint'(a) << FBITS) / longint'(b);
    if (q >= (64'd1 << WIDTH)) return {1'b0, 1'b1, {WIDTH{1'b1}}};
    return {1'b0, 1'b0, q[WIDTH-1:0]};
  endfunction

  // Transaction-level model: accepted operation completes LAT edges later (or at once on /0).
  logic             m_busy = 1'b0, m_ready = 1'b0, m_dbz = 1'b0, m_ovf = 1'b0;
  logic [WIDTH-1:0] m_result = '0;
  logic [WIDTH+1:0] m_pend = '0;
  int               m_left = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy = 1'b0; m_ready = 1'b0; m_dbz = 1'b0; m_ovf = 1'b0; m_result = '0; m_left = 0;
    end else if (m_ready) begin
      m_ready = 1'b0;
      m_busy  = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        {m_dbz, m_ovf, m_result} = m_pend;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_pend = ref_div(operand_1, operand_2);
      if (operand_2 == '0) begin
        m_ready = 1'b1;
        {m_dbz, m_ovf, m_result} = m_pend;
      end else begin
        m_left = LAT;
        m_dbz  = 1'b0;
        m_ovf  = 1'b0;
      end
    end
  end

  // Compare process: handshake every cycle; result and flags whenever they are defined.
  always @(negedge clk) begin
    chk("ready", ready, m_ready);
    chk("busy", busy, m_busy);
    if (!m_busy || m_ready) begin
      chk("result", result, m_result);
      chk("div_by_zero", div_by_zero, m_dbz);
      chk("overflow", overflow, m_ovf);
    end
  end

  // Issue one request from idle, wait (bounded) for ready, check against literals.
  task automatic run_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] er, input logic ed, input logic eo,
                        input int elat);
    int lat = 0;
    bit seen = 0;
    @(negedge clk);
    operand_1 = a; operand_2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    operand_1 = $urandom; operand_2 = $urandom;
    while (lat < 100) begin
      if (ready) begin seen = 1; break; end
      @(negedge clk);
      lat++;
    end
    chk({nm, "_ready_seen"}, 64'(seen), 64'd1);
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_result"}, result, er);
    chk({nm, "_dbz"}, div_by_zero, ed);
    chk({nm, "_ovf"}, overflow, eo);
  endtask

  initial begin
    logic [WIDTH+1:0] r;

    // Pin the reference model itself with hand-computed values.
    r = ref_div(32'h0000_0C00, 32'h0000_0600); chk("model_3_div_1p5", r, {2'b00, 32'h0000_0800});
    r = ref_div(32'h0000_0400, 32'h0000_0C00); chk("model_1_div_3", r, {2'b00, 32'h0000_0155});
    r = ref_div(32'h0000_1400, 32'h0000_0000); chk("model_div0", r, {2'b10, 32'hFFFF_FFFF});
    r = ref_div(32'hFFFF_FFFF, 32'h0000_0001); chk("model_ovf", r, {2'b01, 32'hFFFF_FFFF});

    // Reset for two cycles, with start asserted to show reset wins.
    reset = 1'b0; start = 1'b1; operand_1 = 32'h0000_0C00; operand_2 = 32'h0000_0600;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_busy", busy, 1'b0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", busy, 1'b0);

    run_op("three_div_1p5", 32'h0000_0C00, 32'h0000_0600, 32'h0000_0800, 1'b0, 1'b0, LAT);
    run_op("one_div_three", 32'h0000_0400, 32'h0000_0C00, 32'h0000_0155, 1'b0, 1'b0, LAT);
    run_op("div_by_zero", 32'h0000_1400, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("overflow", 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, LAT);
    run_op("max_fit", 32'h003F_FFFF, 32'h0000_0001, 32'hFFFF_FC00, 1'b0, 1'b0, LAT);

    // Start while busy is ignored.
    @(negedge clk);
    operand_1 = 32'h0000_0C00; operand_2 = 32'h0000_0600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    operand_1 = 32'h0000_0400; operand_2 = 32'h0000_0C00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!ready && n < 100) begin @(negedge clk); n++; end
      chk("ignored_start_latency", 64'(n + 10), 64'(LAT));
      chk("ignored_start_result", result, 32'h0000_0800);
    end
    @(negedge clk);

    // Reset mid-operation aborts with no ready pulse; the next request completes.
    operand_1 = 32'h0000_0C00; operand_2 = 32'h0000_0600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("abort_result", result, 32'h0);
    chk("abort_busy", busy, 1'b0);
    repeat (LAT + 5) begin
      @(negedge clk);
      chk("abort_no_ready", ready, 1'b0);
    end
    run_op("after_abort", 32'h0000_0C00, 32'h0000_0600, 32'h0000_0800, 1'b0, 1'b0, LAT);

    // Randomized traffic; the compare process does all checking here.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: operand_1 = $urandom_range(0, 255) << FBITS;
        1: operand_1 = $urandom;
        2: operand_1 = $urandom_range(0, 15);
        default: operand_1 = $urandom >> $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 7))
        0: operand_2 = '0;
        1: operand_2 = $urandom_range(1, 15);
        2: operand_2 = $urandom_range(1, 64) << FBITS;
        3: operand_2 = $urandom;
        default: operand_2 = ($urandom >> $urandom_range(0, 31)) | 32'h1;
      endcase
      reset = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (LAT + 5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
